mem_lsu: RTL
============

// Module: mem_lsu
// PURPOSE
//  Load/store unit sitting directly upstream of the word-wide data ram.
//  Accepts one byte/half/word load or store per handshake from the datapath, performs
//  alignment checks, extracts and sign/zero-extends loads, and does read-modify-write
//  for sub-word stores. Drives the ram's addr/w_data/we and consumes its
//  combinational read data. Multi-cycle and unpipelined: one request in flight.
// PARAMETERS
//  ADDR_LIMIT  32'h0000_1000  byte addresses >= this value fault (matches ram DEPTH=1024)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   unit can accept; high only in IDLE
//  req_we      in   1   1=store, 0=load
//  req_size    in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_signed  in   1   sign-extend sub-word loads (ignored for word/stores)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  resp_valid  out  1   one-cycle pulse: request completed
//  resp_rdata  out  32  load result; 0 for stores and faults
//  resp_fault  out  1   misaligned, illegal size, or addr >= ADDR_LIMIT
//  ram_addr    out  32  to ram.addr, always word-aligned (low 2 bits 0)
//  ram_w_data  out  32  to ram.w_data
//  ram_we      out  1   to ram.we; high for exactly one cycle per committed store
//  ram_r_data  in   32  from ram.data (combinational read)
// BEHAVIOUR
//  - Reset (async): state=IDLE; all latched request fields, word_q, resp_rdata = 0;
//    resp_valid=0, resp_fault=0, ram_we=0 immediately (ram_we decoded from state only).
//  - Accept: req_valid && req_ready at edge k; latch we/size/signed/addr/wdata.
//  - Fault check at accept: half with addr[0]!=0, word with addr[1:0]!=0, size 11,
//    addr >= ADDR_LIMIT. Fault -> RESP directly; no ram access, no ram_we.
//  - States: IDLE, READ, WRITE, RESP.
//      IDLE : fault->RESP; load->READ; word store->WRITE; byte/half store->READ.
//      READ : ram_addr={addr[31:2],2'b00}; word_q<=ram_r_data; load->RESP, store->WRITE.
//      WRITE: ram_we=1, ram_w_data=merged word -> RESP.
//      RESP : resp_valid=1 with resp_rdata/resp_fault -> IDLE.
//  - Latency (resp_valid cycle after accept edge k): fault k+1; load k+2;
//    word store k+2; sub-word store k+3. Next accept earliest in cycle after RESP.
//  - ram_addr outside READ/WRITE: latched aligned addr (don't-care to ram, no we).
//  - Byte lanes little-endian: addr[1:0]=0 -> bits[7:0] ... 3 -> [31:24];
//    half addr[1]=0 -> [15:0], 1 -> [31:16].
//  - Load extract: lane from word_q, zero- or sign-extended per latched signed; word as-is.
//  - Store merge: word_q with selected lane(s) replaced by wdata[7:0]/[15:0];
//    word store writes wdata unmerged (no READ).
//  - resp_rdata/resp_fault registered, updated on entry to RESP, held until next RESP.
//  - req_* ignored when req_ready=0; no buffering of a second request.
//  - Reset mid-operation: abort; partial RMW never written; ram contents unchanged
//    unless WRITE edge already occurred; no resp_valid for the aborted request.
// STRUCTURE
//  - Package mem_lsu_pkg: enum lsu_size_e {SZ_B, SZ_H, SZ_W, SZ_ILL}; enum
//    lsu_state_e {IDLE, READ, WRITE, RESP}; function is_misaligned(size, addr[1:0]).
//  - Sub-module lsu_lane_align (combinational): inputs word, addr[1:0], size, signed,
//    wdata; outputs load_val and merged_word. Top holds FSM, latches, ram drive.
// TESTING (bench instantiates ram DEPTH=1024 behind the unit)
//  1. Word store 0xDEADBEEF @0x100 -> ram_we 1 cycle, resp k+2 fault=0; word load
//     @0x100 -> resp k+2 rdata=0xDEADBEEF.
//  2. Byte store 0xA5 @0x101 -> READ then WRITE, resp k+3; mem[0x100]=0xDEADA5EF;
//     signed byte load @0x101 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
//  3. Half loads @0x102 over 0xDEADA5EF: signed -> 0xFFFFDEAD, unsigned -> 0x0000DEAD;
//     half store 0x1234 @0x100 -> mem=0xDEAD1234.
//  4. Faults: word @0x102, half @0x101, size 11, word @0x1000 -> resp k+1 fault=1,
//     rdata=0, ram_we never high, memory unchanged.
//  5. req_valid held high across two back-to-back loads -> req_ready low in
//     READ/RESP, second accepted only in IDLE; exactly one resp_valid per request.
//  6. rst pulsed during READ of byte store @0x104 -> ram_we stays 0, mem[0x104]
//     unchanged, no resp_valid, req_ready=1 first cycle after rst falls.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// and the alignment rule used at request accept.
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

  localparam logic [31:0] LSU_ADDR_LIMIT_DEF = 32'h0000_1000;

  // Illegal size is reported separately; this only covers natural alignment.
  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_H:    return addr_lo[0];
      SZ_W:    return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Datapath-side request/response handshake of the load/store unit.
// The datapath is the master, mem_lsu is the slave.
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/mem_lsu_lane_align.sv
// Combinational little-endian lane logic: extracts/extends a load value from a
// ram word and builds the merged word for a sub-word store.
module lsu_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  lsu_size_e   i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_val,
  output logic [31:0] o_merged_word
);

  logic [7:0]  w_lane     [4];
  logic [7:0]  w_new_byte [4];
  logic [3:0]  w_lane_sel;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);

      assign w_lane[gi] = i_word[8*gi +: 8];

      // A half store covers the lane pair selected by addr[1]; word covers all.
      assign w_lane_sel[gi] = (i_size == SZ_B) ? (i_addr_lo == LANE) :
                              (i_size == SZ_H) ? (i_addr_lo[1] == LANE[1]) : 1'b1;

      assign w_new_byte[gi] = (i_size == SZ_B) ? i_wdata[7:0] :
                              (i_size == SZ_H) ? i_wdata[8*(gi%2) +: 8] :
                                                 i_wdata[8*gi +: 8];

      assign o_merged_word[8*gi +: 8] = w_lane_sel[gi] ? w_new_byte[gi] : w_lane[gi];
    end
  endgenerate

  assign w_byte = w_lane[i_addr_lo];
  assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_load_val = i_word;
    case (i_size)
      SZ_B:    o_load_val = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_H:    o_load_val = {{16{i_signed & w_half[15]}}, w_half};
      default: o_load_val = i_word;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Unpipelined load/store unit in front of a word-wide ram with combinational
// read: alignment/range faults, load extension and read-modify-write stores.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = LSU_ADDR_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  mem_lsu_if.slave    io_lsu,
  output logic [31:0] o_ram_addr,
  output logic [31:0] o_ram_w_data,
  output logic        o_ram_we,
  input  logic [31:0] i_ram_r_data
);

  lsu_state_e  r_state;
  lsu_state_e  w_state_next;

  logic        r_we;
  lsu_size_e   r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_rdata;
  logic        r_fault;

  lsu_size_e   w_req_size;
  logic        w_req_fault;
  logic        w_accept;
  logic [31:0] w_align_word;
  logic [31:0] w_load_val;
  logic [31:0] w_merged_word;

  assign w_req_size  = lsu_size_e'(io_lsu.req_size);
  assign w_req_fault = (w_req_size == SZ_ILL)
                     || is_misaligned(w_req_size, io_lsu.req_addr[1:0])
                     || (io_lsu.req_addr >= ADDR_LIMIT);
  assign w_accept    = (r_state == IDLE) && io_lsu.req_valid;

  // In READ the load result is extracted straight from the ram so it can be
  // registered on the same edge that captures the word.
  assign w_align_word = (r_state == READ) ? i_ram_r_data : r_word;

  lsu_lane_align u_lane_align (
    .i_word        (w_align_word),
    .i_addr_lo     (r_addr[1:0]),
    .i_size        (r_size),
    .i_signed      (r_signed),
    .i_wdata       (r_wdata),
    .o_load_val    (w_load_val),
    .o_merged_word (w_merged_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    io_lsu.req_ready  = 1'b0;
    io_lsu.resp_valid = 1'b0;
    o_ram_we          = 1'b0;
    case (r_state)
      IDLE: begin
        io_lsu.req_ready = 1'b1;
        if (io_lsu.req_valid) begin
          if (w_req_fault) begin
            w_state_next = RESP;
          end else if (io_lsu.req_we && (w_req_size == SZ_W)) begin
            w_state_next = WRITE;
          end else begin
            w_state_next = READ;
          end
        end
      end
      READ: begin
        w_state_next = r_we ? WRITE : RESP;
      end
      WRITE: begin
        o_ram_we     = 1'b1;
        w_state_next = RESP;
      end
      RESP: begin
        io_lsu.resp_valid = 1'b1;
        w_state_next      = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_size   <= SZ_B;
      r_signed <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_word   <= 32'd0;
      r_rdata  <= 32'd0;
      r_fault  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= io_lsu.req_we;
        r_size   <= w_req_size;
        r_signed <= io_lsu.req_signed;
        r_addr   <= io_lsu.req_addr;
        r_wdata  <= io_lsu.req_wdata;
        if (w_req_fault) begin
          r_rdata <= 32'd0;
          r_fault <= 1'b1;
        end
      end
      if (r_state == READ) begin
        r_word <= i_ram_r_data;
        if (!r_we) begin
          r_rdata <= w_load_val;
          r_fault <= 1'b0;
        end
      end
      if (r_state == WRITE) begin
        r_rdata <= 32'd0;
        r_fault <= 1'b0;
      end
    end
  end

  assign o_ram_addr        = {r_addr[31:2], 2'b00};
  assign o_ram_w_data      = w_merged_word;
  assign io_lsu.resp_rdata = r_rdata;
  assign io_lsu.resp_fault = r_fault;

endmodule
